// File: rtl/ram_multiport.sv
// ram_multiport
//   Byte-addressed little-endian RAM with R_PORTS read-only ports and one
//   read/write data port with byte enables. Responses come back READ_LAT
//   edges after the accepting edge, fully pipelined and in order. After reset
//   the memory can be zero-filled one RW_WIDTH word per cycle before the
//   block reports ready.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   ready               1 when requests are being accepted
//   r_en/r_addr         per-port read request and byte address
//   r_valid/r_data_out  per-port response strobe and data
//   r_error             per-port out-of-range flag (qualified by r_valid)
//   rw_en/rw_write_en   data-port request, 1 = write / 0 = read
//   rw_be/rw_addr       byte enables and byte address
//   rw_data_in          write data
//   rw_valid            data-port response strobe (reads and writes)
//   rw_data_out         read data, 0 for writes
//   rw_error            out-of-range flag (qualified by rw_valid)
module ram_multiport #(
  parameter int MEM_BYTES      = 4096,
  parameter int R_PORTS        = 1,
  parameter int R_WIDTH        = 32,
  parameter int RW_WIDTH       = 64,
  parameter int ADDR_W         = 64,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        ready,
  input  logic [R_PORTS-1:0]          r_en,
  input  logic [R_PORTS*ADDR_W-1:0]   r_addr,
  output logic [R_PORTS-1:0]          r_valid,
  output logic [R_PORTS*R_WIDTH-1:0]  r_data_out,
  output logic [R_PORTS-1:0]          r_error,
  input  logic                        rw_en,
  input  logic                        rw_write_en,
  input  logic [RW_WIDTH/8-1:0]       rw_be,
  input  logic [ADDR_W-1:0]           rw_addr,
  input  logic [RW_WIDTH-1:0]         rw_data_in,
  output logic                        rw_valid,
  output logic [RW_WIDTH-1:0]         rw_data_out,
  output logic                        rw_error
);

  localparam int R_BYTES     = R_WIDTH / 8;
  localparam int RW_BYTES    = RW_WIDTH / 8;
  localparam int IDX_W       = $clog2(MEM_BYTES);
  localparam int CLEAR_WORDS = MEM_BYTES / RW_BYTES;
  localparam int CLR_W       = $clog2(CLEAR_WORDS) + 1;

  // Last legal start address for an access of N bytes. Comparing against
  // MEM_BYTES-N (instead of computing addr+N) keeps huge addresses from
  // wrapping around into range.
  localparam logic [ADDR_W-1:0] R_LIMIT  = ADDR_W'(MEM_BYTES - R_BYTES);
  localparam logic [ADDR_W-1:0] RW_LIMIT = ADDR_W'(MEM_BYTES - RW_BYTES);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [7:0]               mem_q [MEM_BYTES];
  logic [0:0]               state_q, state_d;
  logic [CLR_W-1:0]         clear_idx_q, clear_idx_d;
  logic                     clear_we_s;
  logic [IDX_W-1:0]         clear_base_s;
  logic                     accept_s;

  logic [R_PORTS-1:0]         r_vld_s, r_err_s;
  logic [R_PORTS*R_WIDTH-1:0] r_dat_s;

  logic                     rw_acc_s, rw_inr_s, rw_wr_s, rw_rd_s, rw_err_s;
  logic [IDX_W-1:0]         rw_base_s;
  logic [RW_WIDTH-1:0]      rw_dat_s;

  // Response pipelines: stage 0 is loaded on the accepting edge, the last
  // stage drives the outputs READ_LAT edges later. Idle stages hold zeros so
  // outputs read 0 whenever valid is low.
  logic [R_PORTS-1:0]         rp_vld_q [READ_LAT+1];
  logic [R_PORTS-1:0]         rp_err_q [READ_LAT+1];
  logic [R_PORTS*R_WIDTH-1:0] rp_dat_q [READ_LAT+1];
  logic                       rwp_vld_q [READ_LAT+1];
  logic                       rwp_err_q [READ_LAT+1];
  logic [RW_WIDTH-1:0]        rwp_dat_q [READ_LAT+1];

  // Clear/run sequencing: next state, clear counter and clear write strobe.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    clear_we_s  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clear_we_s = 1'b1;
          if (clear_idx_q == CLR_W'(CLEAR_WORDS - 1)) begin
            state_d     = ST_RUN;
            clear_idx_d = '0;
          end else begin
            clear_idx_d = clear_idx_q + CLR_W'(1);
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Sequencer registers; reset always restarts the clear from word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  assign ready        = (state_q == ST_RUN);
  assign accept_s     = ready & ~reset;
  assign clear_base_s = IDX_W'(32'(clear_idx_q) * RW_BYTES);

  // Read-only ports: byte gather straight from the array, so a write on the
  // same edge is not yet visible (read-first).
  for (genvar p = 0; p < R_PORTS; p++) begin : g_rport
    logic [ADDR_W-1:0]  addr_s;
    logic               acc_s, inr_s;
    logic [IDX_W-1:0]   base_s;
    logic [R_WIDTH-1:0] dat_s;

    assign addr_s = r_addr[p*ADDR_W +: ADDR_W];
    assign acc_s  = accept_s & r_en[p];
    assign inr_s  = (addr_s <= R_LIMIT);
    assign base_s = addr_s[IDX_W-1:0];

    // Little-endian byte gather; out-of-range or idle reads yield zero.
    always_comb begin
      dat_s = '0;
      for (int b = 0; b < R_BYTES; b++) begin
        if (acc_s && inr_s) begin
          dat_s[b*8 +: 8] = mem_q[base_s + IDX_W'(b)];
        end else begin
          dat_s[b*8 +: 8] = 8'h00;
        end
      end
    end

    assign r_vld_s[p]                     = acc_s;
    assign r_err_s[p]                     = acc_s & ~inr_s;
    assign r_dat_s[p*R_WIDTH +: R_WIDTH]  = dat_s;
  end

  assign rw_acc_s  = accept_s & rw_en;
  assign rw_inr_s  = (rw_addr <= RW_LIMIT);
  assign rw_base_s = rw_addr[IDX_W-1:0];
  assign rw_wr_s   = rw_acc_s & rw_write_en & rw_inr_s;
  assign rw_rd_s   = rw_acc_s & ~rw_write_en & rw_inr_s;
  assign rw_err_s  = rw_acc_s & ~rw_inr_s;

  // Data-port byte gather; writes always answer with zero data.
  always_comb begin
    rw_dat_s = '0;
    for (int b = 0; b < RW_BYTES; b++) begin
      if (rw_rd_s) begin
        rw_dat_s[b*8 +: 8] = mem_q[rw_base_s + IDX_W'(b)];
      end else begin
        rw_dat_s[b*8 +: 8] = 8'h00;
      end
    end
  end

  // Memory array: zero-fill during clear, byte-enabled writes in run.
  always_ff @(posedge clk) begin
    if (!reset && clear_we_s) begin
      for (int b = 0; b < RW_BYTES; b++) begin
        mem_q[clear_base_s + IDX_W'(b)] <= 8'h00;
      end
    end else if (rw_wr_s) begin
      for (int b = 0; b < RW_BYTES; b++) begin
        if (rw_be[b]) begin
          mem_q[rw_base_s + IDX_W'(b)] <= rw_data_in[b*8 +: 8];
        end
      end
    end
  end

  // Latency pipelines for both port types, flushed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= READ_LAT; k++) begin
        rp_vld_q[k]  <= '0;
        rp_err_q[k]  <= '0;
        rp_dat_q[k]  <= '0;
        rwp_vld_q[k] <= 1'b0;
        rwp_err_q[k] <= 1'b0;
        rwp_dat_q[k] <= '0;
      end
    end else begin
      rp_vld_q[0]  <= r_vld_s;
      rp_err_q[0]  <= r_err_s;
      rp_dat_q[0]  <= r_dat_s;
      rwp_vld_q[0] <= rw_acc_s;
      rwp_err_q[0] <= rw_err_s;
      rwp_dat_q[0] <= rw_dat_s;
      for (int k = 1; k <= READ_LAT; k++) begin
        rp_vld_q[k]  <= rp_vld_q[k-1];
        rp_err_q[k]  <= rp_err_q[k-1];
        rp_dat_q[k]  <= rp_dat_q[k-1];
        rwp_vld_q[k] <= rwp_vld_q[k-1];
        rwp_err_q[k] <= rwp_err_q[k-1];
        rwp_dat_q[k] <= rwp_dat_q[k-1];
      end
    end
  end

  assign r_valid     = rp_vld_q[READ_LAT];
  assign r_error     = rp_err_q[READ_LAT];
  assign r_data_out  = rp_dat_q[READ_LAT];
  assign rw_valid    = rwp_vld_q[READ_LAT];
  assign rw_error    = rwp_err_q[READ_LAT];
  assign rw_data_out = rwp_dat_q[READ_LAT];

endmodule

// File: tb/tb_ram_multiport.sv
// tb_ram_multiport
//   Directed and randomized bench for ram_multiport (4 KiB, two 32-bit read
//   ports, 64-bit data port, READ_LAT=3, clear on reset). Expected values come
//   from a byte-array reference model.
module tb_ram_multiport;

  localparam int RL = 3;
  localparam int MB = 4096;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ready;
  logic [1:0]   r_en;
  logic [127:0] r_addr;
  logic [1:0]   r_valid;
  logic [63:0]  r_data_out;
  logic [1:0]   r_error;
  logic         rw_en, rw_write_en;
  logic [7:0]   rw_be;
  logic [63:0]  rw_addr, rw_data_in;
  logic         rw_valid;
  logic [63:0]  rw_data_out;
  logic         rw_error;

  int checks = 0;
  int passes = 0;

  logic [7:0] mm [0:MB-1];

  ram_multiport #(
    .MEM_BYTES(MB), .R_PORTS(2), .R_WIDTH(32), .RW_WIDTH(64), .ADDR_W(64),
    .READ_LAT(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .r_en(r_en), .r_addr(r_addr), .r_valid(r_valid), .r_data_out(r_data_out),
    .r_error(r_error),
    .rw_en(rw_en), .rw_write_en(rw_write_en), .rw_be(rw_be), .rw_addr(rw_addr),
    .rw_data_in(rw_data_in), .rw_valid(rw_valid), .rw_data_out(rw_data_out),
    .rw_error(rw_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    r_en = 2'b00; r_addr = '0;
    rw_en = 1'b0; rw_write_en = 1'b0; rw_be = 8'h00; rw_addr = 64'h0; rw_data_in = 64'h0;
  endtask

  // Reference model: an access of n bytes must lie wholly inside [0, MB).
  task automatic m_rd(input logic [63:0] a, input int n, output logic e, output logic [63:0] d);
    d = 64'h0;
    e = (({1'b0, a} + 65'(n)) > 65'(MB));
    if (!e) for (int b = 0; b < n; b++) d[b*8 +: 8] = mm[int'(a) + b];
  endtask

  task automatic m_wr(input logic [63:0] a, input logic [7:0] be, input logic [63:0] wd);
    if (({1'b0, a} + 65'd8) <= 65'(MB))
      for (int b = 0; b < 8; b++) if (be[b]) mm[int'(a) + b] = wd[b*8 +: 8];
  endtask

  task automatic m_clear;
    for (int i = 0; i < MB; i++) mm[i] = 8'h00;
  endtask

  task automatic rd_port(input int p, input logic [63:0] a, output logic v, output logic e, output logic [31:0] d);
    r_en[p] = 1'b1;
    r_addr[p*64 +: 64] = a;
    tick;
    r_en[p] = 1'b0;
    repeat (RL) tick;
    v = r_valid[p]; e = r_error[p]; d = r_data_out[p*32 +: 32];
  endtask

  task automatic rw_op(input logic we, input logic [7:0] be, input logic [63:0] a, input logic [63:0] wd,
                       output logic v, output logic e, output logic [63:0] d);
    rw_en = 1'b1; rw_write_en = we; rw_be = be; rw_addr = a; rw_data_in = wd;
    tick;
    rw_en = 1'b0; rw_write_en = 1'b0;
    repeat (RL) tick;
    v = rw_valid; e = rw_error; d = rw_data_out;
  endtask

  // Count edges until ready, with requests held active throughout.
  task automatic wait_ready(output int n, output int seen);
    n = 0; seen = 0;
    while (ready !== 1'b1 && n < 2000) begin
      tick;
      n++;
      if (r_valid !== 2'b00 || rw_valid !== 1'b0) seen++;
    end
  endtask

  task automatic drive_busy;
    r_en = 2'b11; r_addr = {64'h100, 64'h100};
    rw_en = 1'b1; rw_write_en = 1'b1; rw_be = 8'hFF; rw_addr = 64'h100;
    rw_data_in = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  initial begin
    logic        v, e, me;
    logic [31:0] d32;
    logic [63:0] d64, md, a, wd;
    logic [7:0]  be;
    int          n, seen, op;

    idle();
    m_clear();
    reset = 1'b1;
    tick; tick;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_valid_err", 64'({r_valid, r_error, rw_valid, rw_error}), 64'd0);
    check("rst_r_data", 64'(r_data_out), 64'd0);
    check("rst_rw_data", rw_data_out, 64'd0);

    // Clear sequence with requests pending (must be ignored)
    reset = 1'b0;
    drive_busy();
    wait_ready(n, seen);
    idle();
    check("clear_edges", 64'(n), 64'd512);
    repeat (RL + 1) begin
      tick;
      if (r_valid !== 2'b00 || rw_valid !== 1'b0) seen++;
    end
    check("clear_no_resp", 64'(seen), 64'd0);
    rd_port(0, 64'h100, v, e, d32);
    check("clear_rd_valid", 64'(v), 64'd1);
    check("clear_rd_data", 64'(d32), 64'd0);
    check("clear_rd_err", 64'(e), 64'd0);

    // Byte-enable write
    rw_op(1'b1, 8'hFF, 64'h40, 64'h1122334455667788, v, e, d64);
    m_wr(64'h40, 8'hFF, 64'h1122334455667788);
    check("wr_valid", 64'(v), 64'd1);
    check("wr_err", 64'(e), 64'd0);
    check("wr_data0", d64, 64'd0);
    rw_op(1'b1, 8'h0F, 64'h40, 64'hAAAAAAAAAAAAAAAA, v, e, d64);
    m_wr(64'h40, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    rw_op(1'b0, 8'h00, 64'h40, 64'h0, v, e, d64);
    check("be_rw_read", d64, 64'h11223344AAAAAAAA);
    rd_port(0, 64'h44, v, e, d32);
    check("be_p0_read", 64'(d32), 64'h11223344);

    // Misaligned and bounds
    rd_port(0, 64'h41, v, e, d32);
    check("misaligned", 64'(d32), 64'h44AAAAAA);
    rd_port(0, 64'hFFD, v, e, d32);
    check("oor_err", 64'(e), 64'd1);
    check("oor_data", 64'(d32), 64'd0);
    check("oor_valid", 64'(v), 64'd1);
    rd_port(0, 64'hFFC, v, e, d32);
    check("edge_err", 64'(e), 64'd0);
    rw_op(1'b0, 8'h00, 64'hFFFFFFFFFFFFFFFC, 64'h0, v, e, d64);
    check("wrap_err", 64'(e), 64'd1);
    check("wrap_data", d64, 64'd0);
    rw_op(1'b1, 8'hFF, 64'hFF9, 64'h5555555555555555, v, e, d64);
    m_wr(64'hFF9, 8'hFF, 64'h5555555555555555);
    check("oor_wr_err", 64'(e), 64'd1);
    rd_port(1, 64'hFF8, v, e, d32);
    check("oor_wr_nochange", 64'(d32), 64'd0);

    // Read-first collision
    rw_en = 1'b1; rw_write_en = 1'b1; rw_be = 8'hFF; rw_addr = 64'h40; rw_data_in = 64'h0;
    r_en[0] = 1'b1; r_addr[63:0] = 64'h40;
    tick;
    idle();
    repeat (RL) tick;
    m_wr(64'h40, 8'hFF, 64'h0);
    check("coll_valid", 64'(r_valid[0]), 64'd1);
    check("coll_old", 64'(r_data_out[31:0]), 64'hAAAAAAAA);
    check("coll_wr_valid", 64'(rw_valid), 64'd1);
    rd_port(0, 64'h40, v, e, d32);
    check("coll_new", 64'(d32), 64'd0);

    // Pipelining on both ports
    for (int k = 0; k < 5; k++) begin
      wd = {$urandom, $urandom};
      rw_op(1'b1, 8'hFF, 64'h200 + 64'(8 * k), wd, v, e, d64);
      m_wr(64'h200 + 64'(8 * k), 8'hFF, wd);
    end
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        r_en = 2'b11;
        r_addr = {64'h204 + 64'(8 * c), 64'h200 + 64'(8 * c)};
      end else begin
        r_en = 2'b00;
      end
      tick;
      if (c >= 3 && c <= 6) begin
        check("pipe_valid", 64'(r_valid), 64'd3);
        m_rd(64'h200 + 64'(8 * (c - 3)), 4, me, md);
        check("pipe_p0", 64'(r_data_out[31:0]), md);
        m_rd(64'h204 + 64'(8 * (c - 3)), 4, me, md);
        check("pipe_p1", 64'(r_data_out[63:32]), md);
      end else begin
        check("pipe_idle", 64'({r_valid, r_data_out}), 64'd0);
      end
    end
    idle();

    // Randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 2);
      a  = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(4080, 4100)) : 64'($urandom_range(0, 1023));
      if (op == 0) begin
        be = 8'($urandom);
        wd = {$urandom, $urandom};
        rw_op(1'b1, be, a, wd, v, e, d64);
        m_wr(a, be, wd);
        m_rd(a, 8, me, md);
        check("rnd_wr_valid", 64'(v), 64'd1);
        check("rnd_wr_err", 64'(e), 64'(me));
        check("rnd_wr_data", d64, 64'd0);
      end else if (op == 1) begin
        rw_op(1'b0, 8'h00, a, 64'h0, v, e, d64);
        m_rd(a, 8, me, md);
        check("rnd_rw_valid", 64'(v), 64'd1);
        check("rnd_rw_err", 64'(e), 64'(me));
        check("rnd_rw_data", d64, md);
      end else begin
        wd = ($urandom_range(0, 1) == 0) ? a : 64'($urandom_range(0, 4100));
        r_en = 2'b11; r_addr = {wd, a};
        tick;
        idle();
        repeat (RL) tick;
        m_rd(a, 4, me, md);
        check("rnd_p0", 64'({r_valid[0], r_error[0], r_data_out[31:0]}), 64'({1'b1, me, md[31:0]}));
        m_rd(wd, 4, me, md);
        check("rnd_p1", 64'({r_valid[1], r_error[1], r_data_out[63:32]}), 64'({1'b1, me, md[31:0]}));
      end
    end

    // Reset in the middle of a clear restarts the count
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    drive_busy();
    seen = 0;
    repeat (200) begin
      tick;
      if (r_valid !== 2'b00 || rw_valid !== 1'b0) seen++;
    end
    check("midclr_ready", 64'(ready), 64'd0);
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    wait_ready(n, op);
    idle();
    m_clear();
    check("midclr_edges", 64'(n), 64'd512);
    check("midclr_no_resp", 64'(seen + op), 64'd0);
    rw_op(1'b0, 8'h00, 64'h200, 64'h0, v, e, d64);
    check("midclr_zeroed", d64, 64'd0);
    rd_port(1, 64'h100, v, e, d32);
    check("midclr_nowrite", 64'({v, e, d32}), 64'({1'b1, 1'b0, 32'h0}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
